servo_pwm_decoder: RTL and testbench

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

---
 rtl/servo_pwm_decoder.sv | 154 +++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high width of a hobby-servo pulse in microseconds and
// maps accepted widths to an angle (-90..+90) and a 10-bit duty value.
module servo_pwm_decoder #(
   parameter int unsigned CLKS_PER_US  = 50,
   parameter int unsigned MIN_US       = 1000,
   parameter int unsigned MAX_US       = 2000,
   parameter int unsigned REJECT_LO_US = 500,
   parameter int unsigned REJECT_HI_US = 2500,
   parameter int unsigned TIMEOUT_US   = 25000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        servo_signal,
   output logic [7:0]  position,
   output logic [9:0]  duty_cycle,
   output logic [15:0] pulse_us,
   output logic        valid,
   output logic        pulse_err,
   output logic        timeout
);

   localparam int unsigned    PW         = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLKS_PER_US - 1);
   localparam int unsigned    SPAN       = MAX_US - MIN_US;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd1;
   localparam logic [1:0] S_LOW  = 2'd2;

   logic          sync1, sync2, prev;
   logic [1:0]    fill;
   logic          armed;
   logic          rise, fall;
   logic [PW-1:0] presc;
   logic [15:0]   us_cnt, to_cnt;
   logic          wrap, timer_hit;
   logic [15:0]   width_now, width_q;
   logic          width_bad;
   logic [1:0]    state;
   logic          meas_pend, err_pend;
   logic [31:0]   wc, off;
   logic [7:0]    pos_q;
   logic [9:0]    duty_q;

   // Edges are only honoured once a genuine low has passed through the synchronizer,
   // so a pulse already high when reset releases is never measured.
   assign rise = sync2 & ~prev & armed;
   assign fall = ~sync2 & prev & armed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         fill  <= '0;
         armed <= 1'b0;
      end else begin
         sync1 <= servo_signal;
         sync2 <= sync1;
         prev  <= sync2;
         if (fill != 2'd2) fill <= fill + 2'd1;
         if (fill == 2'd2 && !sync2) armed <= 1'b1;
      end
   end

   assign wrap      = (presc == PRESC_LAST);
   assign timer_hit = (32'(to_cnt) >= TIMEOUT_US);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc  <= '0;
         us_cnt <= '0;
         to_cnt <= '0;
      end else if (rise) begin
         presc  <= '0;
         us_cnt <= '0;
         to_cnt <= '0;
      end else begin
         presc <= wrap ? '0 : presc + PW'(1);
         if (wrap && !(&us_cnt)) us_cnt <= us_cnt + 16'd1;
         if (wrap && !(&to_cnt)) to_cnt <= to_cnt + 16'd1;
      end
   end

   // The fall cycle itself still belongs to the high time, so count it when it completes a microsecond.
   assign width_now = (wrap && !(&us_cnt)) ? us_cnt + 16'd1 : us_cnt;
   assign width_bad = (32'(width_now) < REJECT_LO_US) || (32'(width_now) > REJECT_HI_US);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         timeout   <= 1'b0;
         width_q   <= '0;
         meas_pend <= 1'b0;
         err_pend  <= 1'b0;
      end else begin
         meas_pend <= 1'b0;
         err_pend  <= 1'b0;
         if (rise) begin
            state   <= S_HIGH;
            timeout <= 1'b0;
         end else begin
            case (state)
               S_HIGH: begin
                  if (fall) begin
                     state     <= S_LOW;
                     width_q   <= width_now;
                     meas_pend <= !width_bad;
                     err_pend  <= width_bad;
                  end else if (timer_hit) begin
                     state   <= S_IDLE;
                     timeout <= 1'b1;
                  end
               end
               S_LOW: begin
                  if (timer_hit) begin
                     state   <= S_IDLE;
                     timeout <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      wc = 32'(width_q);
      if (wc < MIN_US)      wc = MIN_US;
      else if (wc > MAX_US) wc = MAX_US;
      off    = wc - MIN_US;
      pos_q  = 8'((off * 32'd180) / SPAN);
      duty_q = 10'((off * 32'd1023) / SPAN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         position   <= '0;
         duty_cycle <= 10'd511;
         pulse_us   <= 16'd1500;
         valid      <= 1'b0;
         pulse_err  <= 1'b0;
      end else begin
         valid     <= meas_pend;
         pulse_err <= err_pend;
         if (meas_pend) begin
            position   <= pos_q - 8'd90;
            duty_cycle <= duty_q;
            pulse_us   <= width_q;
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder; one clock per microsecond keeps runs short.
module tb_servo_pwm_decoder;

   localparam int C_MIN = 1000, C_MAX = 2000, C_RLO = 500, C_RHI = 2500, C_TO = 25000;

   logic        clk = 1'b0;
   logic        reset;
   logic        servo_signal;
   logic [7:0]  position;
   logic [9:0]  duty_cycle;
   logic [15:0] pulse_us;
   logic        valid, pulse_err, timeout;

   int checks = 0, errors = 0;
   int exp_pos, exp_duty, exp_us;
   int v_cnt, v_at, e_cnt, e_at, to_at;

   always #5 clk = ~clk;

   servo_pwm_decoder #(
      .CLKS_PER_US(1), .MIN_US(C_MIN), .MAX_US(C_MAX),
      .REJECT_LO_US(C_RLO), .REJECT_HI_US(C_RHI), .TIMEOUT_US(C_TO)
   ) dut (
      .clk(clk), .reset(reset), .servo_signal(servo_signal),
      .position(position), .duty_cycle(duty_cycle), .pulse_us(pulse_us),
      .valid(valid), .pulse_err(pulse_err), .timeout(timeout)
   );

   task automatic clear_obs();
      v_cnt = 0; v_at = 0; e_cnt = 0; e_at = 0; to_at = 0;
   endtask

   // Hold the input at lvl for n clocks, logging strobes by clock index within this phase.
   task automatic drive(input logic lvl, input int n);
      servo_signal = lvl;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (valid === 1'b1) begin v_cnt++; v_at = k; end
         if (pulse_err === 1'b1) begin e_cnt++; e_at = k; end
         if (timeout === 1'b1 && to_at == 0) to_at = k;
      end
   endtask

   task automatic model_reset();
      exp_pos = 0; exp_duty = 511; exp_us = 1500;
   endtask

   task automatic model_pulse(input int w, output bit acc);
      int wc;
      acc = (w >= C_RLO) && (w <= C_RHI);
      if (acc) begin
         wc = (w < C_MIN) ? C_MIN : (w > C_MAX) ? C_MAX : w;
         exp_pos  = ((wc - C_MIN) * 180) / (C_MAX - C_MIN) - 90;
         exp_duty = ((wc - C_MIN) * 1023) / (C_MAX - C_MIN);
         exp_us   = w;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; servo_signal = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if (position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty) || pulse_us !== 16'(exp_us)) begin
         errors++;
         $display("FAIL reset_outputs: pos=%0d duty=%0d us=%0d, required %0d/%0d/%0d",
                  $signed(position), duty_cycle, pulse_us, exp_pos, exp_duty, exp_us);
      end
      checks++;
      if (valid !== 1'b0 || pulse_err !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b err=%b timeout=%b, required 0/0/0", valid, pulse_err, timeout);
      end
      reset = 1'b0;
      drive(1'b0, 10);
   endtask

   task automatic test_nominal();
      bit acc;
      int lows[2] = '{18500, 400};
      for (int i = 0; i < 2; i++) begin
         clear_obs();
         drive(1'b1, 1500);
         drive(1'b0, lows[i]);
         model_pulse(1500, acc);
         checks++;
         if (v_cnt !== 1 || v_at !== 4 || e_cnt !== 0) begin
            errors++;
            $display("FAIL nominal_%0d_strobe: valid %0d at %0d err %0d, required 1 at 4 err 0", i, v_cnt, v_at, e_cnt);
         end
         checks++;
         if (position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty) || pulse_us !== 16'(exp_us)) begin
            errors++;
            $display("FAIL nominal_%0d_outputs: pos=%0d duty=%0d us=%0d, required %0d/%0d/%0d", i,
                     $signed(position), duty_cycle, pulse_us, exp_pos, exp_duty, exp_us);
         end
      end
   endtask

   task automatic test_mapping();
      bit acc;
      int ws[3] = '{1000, 2000, 1250};
      for (int i = 0; i < 3; i++) begin
         clear_obs();
         drive(1'b1, ws[i]);
         drive(1'b0, 400);
         model_pulse(ws[i], acc);
         checks++;
         if (v_cnt !== 1 || v_at !== 4 || e_cnt !== 0) begin
            errors++;
            $display("FAIL map_%0d_strobe: valid %0d at %0d err %0d, required 1 at 4 err 0", ws[i], v_cnt, v_at, e_cnt);
         end
         checks++;
         if (position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty) || pulse_us !== 16'(exp_us)) begin
            errors++;
            $display("FAIL map_%0d_outputs: pos=%0d duty=%0d us=%0d, required %0d/%0d/%0d", ws[i],
                     $signed(position), duty_cycle, pulse_us, exp_pos, exp_duty, exp_us);
         end
      end
   endtask

   task automatic test_clamp_reject();
      bit acc;
      int ws[5] = '{800, 400, 499, 500, 2501};
      for (int i = 0; i < 5; i++) begin
         clear_obs();
         drive(1'b1, ws[i]);
         drive(1'b0, 400);
         model_pulse(ws[i], acc);
         checks++;
         if (acc && (v_cnt !== 1 || v_at !== 4 || e_cnt !== 0)) begin
            errors++;
            $display("FAIL edge_%0d_accept: valid %0d at %0d err %0d, required 1 at 4 err 0", ws[i], v_cnt, v_at, e_cnt);
         end else if (!acc && (e_cnt !== 1 || e_at !== 4 || v_cnt !== 0)) begin
            errors++;
            $display("FAIL edge_%0d_reject: err %0d at %0d valid %0d, required 1 at 4 valid 0", ws[i], e_cnt, e_at, v_cnt);
         end
         checks++;
         if (position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty) || pulse_us !== 16'(exp_us)) begin
            errors++;
            $display("FAIL edge_%0d_outputs: pos=%0d duty=%0d us=%0d, required %0d/%0d/%0d", ws[i],
                     $signed(position), duty_cycle, pulse_us, exp_pos, exp_duty, exp_us);
         end
      end
   endtask

   task automatic test_timeout();
      bit acc;
      int exp_k;
      clear_obs();
      drive(1'b1, 2000);
      drive(1'b0, 28000);
      model_pulse(2000, acc);
      exp_k = C_TO - 2000;
      checks++;
      if (to_at < exp_k || to_at > exp_k + 6) begin
         errors++;
         $display("FAIL timeout_assert: first high at low-phase clock %0d, required %0d..%0d", to_at, exp_k, exp_k + 6);
      end
      checks++;
      if (timeout !== 1'b1 || v_cnt !== 1) begin
         errors++;
         $display("FAIL timeout_level: timeout=%b valids=%0d, required 1 and 1", timeout, v_cnt);
      end
      clear_obs();
      drive(1'b1, 1500);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: timeout=%b after rise, required 0", timeout);
      end
      drive(1'b0, 400);
      model_pulse(1500, acc);
      checks++;
      if (v_cnt !== 1 || v_at !== 4 || position !== 8'(exp_pos) || pulse_us !== 16'(exp_us)) begin
         errors++;
         $display("FAIL timeout_recover: valid %0d at %0d pos=%0d us=%0d, required 1 at 4 %0d/%0d",
                  v_cnt, v_at, $signed(position), pulse_us, exp_pos, exp_us);
      end
   endtask

   task automatic test_reset_while_high();
      bit acc;
      servo_signal = 1'b1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      clear_obs();
      drive(1'b1, 800);
      drive(1'b0, 400);
      checks++;
      if (v_cnt !== 0 || e_cnt !== 0 || position !== 8'(exp_pos) || pulse_us !== 16'(exp_us)) begin
         errors++;
         $display("FAIL rel_high_ignore: valid %0d err %0d pos=%0d us=%0d, required 0 0 %0d/%0d",
                  v_cnt, e_cnt, $signed(position), pulse_us, exp_pos, exp_us);
      end
      clear_obs();
      drive(1'b1, 1250);
      drive(1'b0, 400);
      model_pulse(1250, acc);
      checks++;
      if (v_cnt !== 1 || v_at !== 4 || position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty)) begin
         errors++;
         $display("FAIL rel_high_next: valid %0d at %0d pos=%0d duty=%0d, required 1 at 4 %0d/%0d",
                  v_cnt, v_at, $signed(position), duty_cycle, exp_pos, exp_duty);
      end
   endtask

   task automatic test_reset_mid_pulse();
      clear_obs();
      drive(1'b1, 700);
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty) || pulse_us !== 16'(exp_us)) begin
         errors++;
         $display("FAIL mid_reset_async: pos=%0d duty=%0d us=%0d, required %0d/%0d/%0d",
                  $signed(position), duty_cycle, pulse_us, exp_pos, exp_duty, exp_us);
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      clear_obs();
      drive(1'b1, 300);
      drive(1'b0, 400);
      checks++;
      if (v_cnt !== 0 || e_cnt !== 0 || position !== 8'(exp_pos) || pulse_us !== 16'(exp_us)) begin
         errors++;
         $display("FAIL mid_reset_quiet: valid %0d err %0d pos=%0d us=%0d, required 0 0 %0d/%0d",
                  v_cnt, e_cnt, $signed(position), pulse_us, exp_pos, exp_us);
      end
   endtask

   task automatic test_random();
      bit acc;
      int w;
      for (int i = 0; i < 4; i++) begin
         w = int'($urandom_range(2800, 300));
         clear_obs();
         drive(1'b1, w);
         drive(1'b0, 300);
         model_pulse(w, acc);
         checks++;
         if (acc && (v_cnt !== 1 || v_at !== 4 || e_cnt !== 0)) begin
            errors++;
            $display("FAIL rand_%0d_accept: valid %0d at %0d err %0d, required 1 at 4 err 0", w, v_cnt, v_at, e_cnt);
         end else if (!acc && (e_cnt !== 1 || e_at !== 4 || v_cnt !== 0)) begin
            errors++;
            $display("FAIL rand_%0d_reject: err %0d at %0d valid %0d, required 1 at 4 valid 0", w, e_cnt, e_at, v_cnt);
         end
         checks++;
         if (position !== 8'(exp_pos) || duty_cycle !== 10'(exp_duty) || pulse_us !== 16'(exp_us)) begin
            errors++;
            $display("FAIL rand_%0d_outputs: pos=%0d duty=%0d us=%0d, required %0d/%0d/%0d", w,
                     $signed(position), duty_cycle, pulse_us, exp_pos, exp_duty, exp_us);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_mapping();
      test_clamp_reject();
      test_timeout();
      test_reset_while_high();
      test_reset_mid_pulse();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
